// File: rtl/us_ranger.sv
// Ultrasonic ranger: fires a trigger pulse, times the echo width and reports distance in cm or a timeout.
// Define US_RANGER_ECHO_SYNC_EN to pass the echo pin through a 2-flop synchronizer.
module us_ranger #(
  parameter int unsigned TRIG_CYCLES     = 500,
  parameter int unsigned CYCLES_PER_UNIT = 2915,
  parameter int unsigned MAX_UNITS       = 400,
  parameter int unsigned ECHO_WAIT_MAX   = 50000,
  parameter int unsigned HOLDOFF_CYCLES  = 3000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        echo,
  output logic        trig,
  output logic [22:0] distance,
  output logic        time_out,
  output logic        valid
);

  localparam int unsigned UNITS_W = 23;
  localparam int unsigned SUB_W   = $clog2(CYCLES_PER_UNIT + 1);
  localparam int unsigned CNT_MAX0 = (TRIG_CYCLES > ECHO_WAIT_MAX) ? TRIG_CYCLES : ECHO_WAIT_MAX;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > HOLDOFF_CYCLES) ? CNT_MAX0 : HOLDOFF_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    TRIG_PEND,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SUB_W-1:0]   sub;
  logic [UNITS_W-1:0] units;
  logic               echo_s;
  logic               echo_p;
  logic               rise;
  logic [CNT_W-1:0]   cnt_inc;
  logic [SUB_W-1:0]   sub_inc;
  logic [UNITS_W-1:0] units_inc;

`ifdef US_RANGER_ECHO_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], echo};
  end

  assign echo_s = sync[1];
`else
  assign echo_s = echo;
`endif

  assign rise      = echo_s & ~echo_p;
  assign cnt_inc   = cnt + CNT_W'(1);
  assign sub_inc   = sub + SUB_W'(1);
  assign units_inc = units + UNITS_W'(1);

  always_ff @(posedge clk) begin
    if (rst) echo_p <= 1'b0;
    else     echo_p <= echo_s;
  end

  // Measurement sequencer; the single shared counter times trigger, echo wait and holdoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TRIG_PEND;
      cnt      <= '0;
      sub      <= '0;
      units    <= '0;
      trig     <= 1'b0;
      distance <= '0;
      time_out <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        TRIG_PEND: begin
          trig  <= 1'b1;
          cnt   <= CNT_W'(1);
          state <= TRIG;
        end
        TRIG: begin
          if (cnt == CNT_W'(TRIG_CYCLES)) begin
            trig  <= 1'b0;
            cnt   <= '0;
            state <= WAIT_RISE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_RISE: begin
          // A rise on the limit clock still wins over the timeout.
          if (rise) begin
            sub   <= SUB_W'(1);
            units <= '0;
            state <= MEASURE;
          end else if (cnt_inc == CNT_W'(ECHO_WAIT_MAX)) begin
            time_out <= 1'b1;
            valid    <= 1'b1;
            cnt      <= '0;
            state    <= HOLDOFF;
          end else begin
            cnt <= cnt_inc;
          end
        end
        MEASURE: begin
          if (!echo_s) begin
            distance <= units;
            time_out <= 1'b0;
            valid    <= 1'b1;
            cnt      <= '0;
            state    <= HOLDOFF;
          end else if (sub_inc == SUB_W'(CYCLES_PER_UNIT)) begin
            sub   <= '0;
            units <= units_inc;
            if (units_inc == UNITS_W'(MAX_UNITS)) begin
              time_out <= 1'b1;
              valid    <= 1'b1;
              cnt      <= '0;
              state    <= HOLDOFF;
            end
          end else begin
            sub <= sub_inc;
          end
        end
        HOLDOFF: begin
          if (cnt_inc == CNT_W'(HOLDOFF_CYCLES)) begin
            cnt   <= '0;
            state <= TRIG_PEND;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          trig  <= 1'b0;
          cnt   <= '0;
          state <= TRIG_PEND;
        end
      endcase
    end
  end

endmodule
